flasher_trigger_ctrl: RTL and testbench

//  Upstream conditioner for the ring LED flasher. Synchronises and debounces the raw

---
 rtl/flasher_pkg.sv | 15 +
 rtl/flasher_trigger_ctrl_debounce_cell.sv | 103 ++++++++++
 rtl/flasher_trigger_ctrl.sv | 97 +++++++++
 tb/tb_flasher_trigger_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/flasher_pkg.sv
// rtl/flasher_pkg.sv - shared state encoding and helpers for flasher-side controllers
package flasher_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } flasher_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flasher_trigger_ctrl_debounce_cell.sv
// rtl/flasher_trigger_ctrl_debounce_cell.sv - button synchroniser, debounce FSM and press event
module debounce_cell
    import flasher_pkg::*;
#(
    parameter int DB_CNT = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           btn_raw,
    output logic           btn_db,
    output logic           press_evt,
    output flasher_state_e state
);

    localparam int DW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CNT - 1);

    logic           sync_a;
    logic           btn_s;
    logic [DW-1:0]  cnt;
    logic [DW-1:0]  cnt_inc;
    logic [DW-1:0]  cnt_next;
    flasher_state_e state_next;
    logic           db_next;

    // The terminal test looks at the incremented value so that acceptance lands
    // on the same edge the count reaches its last value.
    assign cnt_inc = cnt + DW'(1);

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            btn_s  <= sync_a;
        end
    end

    // State, debounce counter and debounced level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RELEASED;
            cnt    <= '0;
            btn_db <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            btn_db <= db_next;
        end
    end

    // Next-state logic; a press event marks the PRESS_WAIT -> PRESSED transition only.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        press_evt  = 1'b0;
        case (state)
            RELEASED: begin
                if (btn_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt_inc == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = cnt_inc;
                    press_evt  = 1'b1;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_inc == DB_LAST) begin
                    state_next = RELEASED;
                    cnt_next   = cnt_inc;
                end else begin
                    cnt_next   = cnt_inc;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
        db_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

endmodule

// File: rtl/flasher_trigger_ctrl.sv
// rtl/flasher_trigger_ctrl.sv - button conditioner and step divider for the ring flasher (option AUTO_REPEAT_EN)
module flasher_trigger_ctrl
    import flasher_pkg::*;
#(
    parameter int DB_CNT     = 1_000_000,
    parameter int STEP_DIV   = 25_000_000,
    parameter int HOLD_CNT   = 50_000_000,
    parameter int REPEAT_CNT = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic enable,
    output logic btn_db,
    output logic repeat_pulse,
    output logic step_tick
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

    flasher_state_e db_state;
    logic           press_evt;
    logic           auto_hit;
    logic           rp_next;
    logic           tick_next;
    logic [SW-1:0]  div_cnt;
    logic [SW-1:0]  div_next;

    debounce_cell #(
        .DB_CNT (DB_CNT)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_db    (btn_db),
        .press_evt (press_evt),
        .state     (db_state)
    );

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(max2(HOLD_CNT, REPEAT_CNT));
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CNT - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CNT - 1);

    logic [HW-1:0] hold_cnt;
    logic          repeating;

    assign auto_hit = (db_state == PRESSED) &&
                      (hold_cnt == (repeating ? REPEAT_LAST : HOLD_LAST));

    // Hold timer: restarts on a fresh press, runs only in PRESSED, frozen in RELEASE_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (press_evt) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
        end else if (auto_hit) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
        end else if (db_state == PRESSED) begin
            hold_cnt  <= hold_cnt + HW'(1);
        end
    end
`else
    logic unused_cfg;

    assign auto_hit   = 1'b0;
    assign unused_cfg = ^{db_state, 32'(HOLD_CNT), 32'(REPEAT_CNT)};
`endif

    // Pulse gating and divider next values; a pulse clears the divider on the following edge.
    always_comb begin
        rp_next  = enable && (press_evt || auto_hit);
        div_next = '0;
        if (enable && !repeat_pulse && (div_cnt != STEP_LAST)) begin
            div_next = div_cnt + SW'(1);
        end
        tick_next = enable && !rp_next && (div_next == STEP_LAST);
    end

    // Output and divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            repeat_pulse <= 1'b0;
            step_tick    <= 1'b0;
        end else begin
            div_cnt      <= div_next;
            repeat_pulse <= rp_next;
            step_tick    <= tick_next;
        end
    end

endmodule

// File: tb/tb_flasher_trigger_ctrl.sv
// tb/tb_flasher_trigger_ctrl.sv - directed bench for flasher_trigger_ctrl (honours AUTO_REPEAT_EN)
module tb_flasher_trigger_ctrl;

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic btn_raw;
    logic enable;
    logic btn_db;
    logic repeat_pulse;
    logic step_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flasher_trigger_ctrl #(
        .DB_CNT     (4),
        .STEP_DIV   (5),
        .HOLD_CNT   (10),
        .REPEAT_CNT (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw      (btn_raw),
        .enable       (enable),
        .btn_db       (btn_db),
        .repeat_pulse (repeat_pulse),
        .step_tick    (step_tick)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] bitat(input int n);
        logic [63:0] v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // raw[k] is driven during cycle k; pul/db[k] are expected in cycle k.
    task automatic run_seq(input string tag, input logic [63:0] raw, input logic [63:0] pul,
                           input logic [63:0] db, input int n);
        for (int k = 0; k < n; k++) begin
            btn_raw = raw[k];
            cyc();
            chk($sformatf("%s_pulse_c%0d", tag, k + 1), repeat_pulse, pul[k + 1]);
            chk($sformatf("%s_db_c%0d", tag, k + 1), btn_db, db[k + 1]);
        end
        btn_raw = 1'b0;
    endtask

    task automatic idle(input int n);
        btn_raw = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        int t;
        logic [63:0] auto_mask;

        rst_n   = 1'b0;
        btn_raw = 1'b0;
        enable  = 1'b1;
        repeat (3) cyc();
        chk("rst_db", btn_db, 1'b0);
        chk("rst_pulse", repeat_pulse, 1'b0);
        chk("rst_tick", step_tick, 1'b0);
        rst_n = 1'b1;

        // Idle ticks every 5 cycles; a press accepted on a terminal count suppresses that tick.
        t = 0;
        while (step_tick !== 1'b1 && t < 12) begin
            cyc();
            t++;
        end
        chk("t4_sync", step_tick, 1'b1);
        for (int k = 0; k < 19; k++) begin
            btn_raw = (k >= 4);
            cyc();
            chk($sformatf("t4_tick_c%0d", k + 1), step_tick, (k + 1 == 5) || (k + 1 == 15));
            chk($sformatf("t4_pulse_c%0d", k + 1), repeat_pulse, (k + 1 == 10));
        end
        idle(14);

        // Clean press held 20 cycles.
        auto_mask = AUTO ? (bitat(16) | bitat(22)) : '0;
        run_seq("t1", span(0, 19), bitat(6) | auto_mask, span(6, 25), 30);
        idle(6);

        // Bounce 1,0,1,0 then steady high.
        run_seq("t2", span(0, 1) | span(4, 5) | span(8, 19), bitat(14), span(14, 25), 30);
        idle(6);

        // Two-cycle release glitch while held; the hold timer freezes across it.
        auto_mask = AUTO ? bitat(18) : '0;
        run_seq("t3", span(0, 9) | span(12, 19), bitat(6) | auto_mask, span(6, 25), 30);
        idle(6);

        // Press while disabled, then enable: no replayed pulse, first tick after 5 cycles.
        for (int k = 0; k < 20; k++) begin
            enable  = (k >= 12);
            btn_raw = (k < 8);
            cyc();
            chk($sformatf("t5_pulse_c%0d", k + 1), repeat_pulse, 1'b0);
            chk($sformatf("t5_tick_c%0d", k + 1), step_tick, (k + 1 == 16));
            chk($sformatf("t5_db_c%0d", k + 1), btn_db, (k + 1 >= 6) && (k + 1 < 14));
        end
        enable = 1'b1;
        idle(6);

        // Long hold: auto-repeat cadence when enabled, single pulse otherwise.
        auto_mask = AUTO ? (bitat(16) | bitat(22) | bitat(28)) : '0;
        run_seq("t6", span(0, 29), bitat(6) | auto_mask, span(6, 35), 38);
        idle(6);

        // Asynchronous reset in the middle of a hold.
        btn_raw = 1'b1;
        repeat (16) cyc();
        chk("t6r_db_pre", btn_db, 1'b1);
        chk("t6r_pulse_pre", repeat_pulse, AUTO);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r_db", btn_db, 1'b0);
        chk("t6r_pulse", repeat_pulse, 1'b0);
        chk("t6r_tick", step_tick, 1'b0);
        btn_raw = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("t6r_db_post", btn_db, 1'b0);
        chk("t6r_pulse_post", repeat_pulse, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
